airlock_pressure_ctrl: RTL and testbench

Parametrised airlock chamber pressure controller with a multi-level pressure model, a configurable ramp rate, pause on door-open, and direction reversal mid-ramp. The block sits between the airlock door sensors and operator request buttons and the chamber status/indicator logic. It replaces the fixed single-bit pressurized/depressurized controller. It reports the instantaneous pressure level, busy/fault status, and a completion pulse.

---
 rtl/airlock_pressure_ctrl.sv | 113 +++++++++++
 tb/tb_airlock_pressure_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_pressure_ctrl.sv
// rtl/airlock_pressure_ctrl.sv - multi-level airlock pressure ramp controller with door hold and reversal
module airlock_pressure_ctrl #(
    parameter int LEVEL_W     = 4,
    parameter int MAX_LEVEL   = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               press_n,
    input  logic               depress_n,
    input  logic               inner_open,
    input  logic               outer_open,
    output logic [LEVEL_W-1:0] level,
    output logic               pressurized,
    output logic               depressurized,
    output logic               busy,
    output logic               fault,
    output logic               done
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE, PRESS, DEPRESS, HOLD} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LEVEL_W-1:0] level_q;
    logic               dir_q;
    logic               done_q;

    logic               doors_closed;
    logic               up_req;
    logic               dn_req;
    logic               dir_now;
    logic               opp_req;
    logic               flip_at_tgt;
    logic [LEVEL_W-1:0] level_d;
    logic               step_at_tgt;

    assign doors_closed = !inner_open && !outer_open;
    assign up_req       = !press_n && depress_n;
    assign dn_req       = !depress_n && press_n;

    // In HOLD the direction lives in dir_q; while ramping the state itself is the direction.
    assign dir_now      = (state_q == PRESS) || ((state_q == HOLD) && dir_q);
    assign opp_req      = dir_now ? dn_req : up_req;
    assign flip_at_tgt  = dir_now ? (level_q == '0) : (level_q == LVL_MAX);
    assign level_d      = dir_now ? (level_q + LEVEL_W'(1)) : (level_q - LEVEL_W'(1));
    assign step_at_tgt  = dir_now ? (level_d == LVL_MAX) : (level_d == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (up_req && doors_closed && (level_q != LVL_MAX)) begin
                        state_q <= PRESS;
                        dir_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else if (dn_req && doors_closed && (level_q != '0)) begin
                        state_q <= DEPRESS;
                        dir_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    dir_q <= dir_now;
                    if ((state_q != HOLD) && !doors_closed) begin
                        state_q <= HOLD;
                    end else if (opp_req) begin
                        cnt_q <= '0;
                        dir_q <= !dir_now;
                        if (flip_at_tgt)
                            state_q <= IDLE;
                        else if (doors_closed)
                            state_q <= dir_now ? DEPRESS : PRESS;
                        else
                            state_q <= HOLD;
                    end else if (doors_closed) begin
                        // Resuming from HOLD counts this edge as an enabled cycle of the step.
                        state_q <= dir_now ? PRESS : DEPRESS;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            level_q <= level_d;
                            if (step_at_tgt) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign level         = level_q;
    assign pressurized   = (level_q == LVL_MAX);
    assign depressurized = (level_q == '0);
    assign busy          = (state_q != IDLE);
    assign fault         = (state_q == HOLD);
    assign done          = done_q;

endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
// tb/tb_airlock_pressure_ctrl.sv - self-checking bench for airlock_pressure_ctrl (two parameter sets)
module tb_airlock_pressure_ctrl;

    logic clk = 1'b0;
    logic reset, press_n, depress_n, inner_open, outer_open;

    logic [3:0] level_a, level_b;
    logic press_a, depr_a, busy_a, fault_a, done_a;
    logic press_b, depr_b, busy_b, fault_b, done_b;

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b0;

    always #5 clk = ~clk;

    airlock_pressure_ctrl #(.LEVEL_W(4), .MAX_LEVEL(8), .STEP_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .press_n(press_n), .depress_n(depress_n),
        .inner_open(inner_open), .outer_open(outer_open), .level(level_a),
        .pressurized(press_a), .depressurized(depr_a), .busy(busy_a),
        .fault(fault_a), .done(done_a)
    );

    airlock_pressure_ctrl #(.LEVEL_W(4), .MAX_LEVEL(15), .STEP_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .press_n(press_n), .depress_n(depress_n),
        .inner_open(inner_open), .outer_open(outer_open), .level(level_b),
        .pressurized(press_b), .depressurized(depr_b), .busy(busy_b),
        .fault(fault_b), .done(done_b)
    );

    // Reference: chamber as an integer level, progress as enabled cycles spent on the current step.
    typedef struct {
        int lvl;
        int cnt;
        int dir;
        bit moving;
        bit hold;
        bit done;
    } mstate_t;

    mstate_t ma = '{lvl: 0, cnt: 0, dir: -1, moving: 0, hold: 0, done: 0};
    mstate_t mb = '{lvl: 0, cnt: 0, dir: -1, moving: 0, hold: 0, done: 0};

    function automatic mstate_t mstep(mstate_t s, int maxl, int steps,
                                      bit rstn, bit pn, bit dn, bit io, bit oo);
        bit closed = !io && !oo;
        bit upr    = !pn && dn;
        bit dnr    = !dn && pn;
        bit opp;
        s.done = 0;
        if (!rstn) begin
            s.lvl = 0; s.cnt = 0; s.dir = -1; s.moving = 0; s.hold = 0;
            return s;
        end
        if (!s.moving) begin
            if (upr && closed && s.lvl < maxl) begin
                s.moving = 1; s.dir = 1; s.cnt = 0;
            end else if (dnr && closed && s.lvl > 0) begin
                s.moving = 1; s.dir = -1; s.cnt = 0;
            end
            return s;
        end
        opp = (s.dir > 0) ? dnr : upr;
        if (!s.hold && !closed) begin
            s.hold = 1;
            return s;
        end
        if (opp) begin
            s.dir = -s.dir;
            s.cnt = 0;
            if (s.lvl == ((s.dir > 0) ? maxl : 0)) begin
                s.moving = 0; s.hold = 0;
            end else if (closed) begin
                s.hold = 0;
            end
            return s;
        end
        if (!closed) return s;
        s.hold = 0;
        s.cnt++;
        if (s.cnt == steps) begin
            s.cnt = 0;
            s.lvl += s.dir;
            if (s.lvl == ((s.dir > 0) ? maxl : 0)) begin
                s.moving = 0; s.done = 1;
            end
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ma = mstep(ma, 8, 4, reset, press_n, depress_n, inner_open, outer_open);
        mb = mstep(mb, 15, 1, reset, press_n, depress_n, inner_open, outer_open);
    end

    always @(negedge clk) begin
        if (sb_en) begin
            chk("sb_a_level", level_a, ma.lvl);
            chk("sb_a_press", press_a, ma.lvl == 8);
            chk("sb_a_depr",  depr_a,  ma.lvl == 0);
            chk("sb_a_busy",  busy_a,  ma.moving);
            chk("sb_a_fault", fault_a, ma.hold);
            chk("sb_a_done",  done_a,  ma.done);
            chk("sb_b_level", level_b, mb.lvl);
            chk("sb_b_press", press_b, mb.lvl == 15);
            chk("sb_b_busy",  busy_b,  mb.moving);
            chk("sb_b_fault", fault_b, mb.hold);
            chk("sb_b_done",  done_b,  mb.done);
        end
    end

    // Drive one edge's worth of inputs, return at the following negedge.
    task automatic cyc(input bit rs, input bit pn, input bit dn, input bit io, input bit oo);
        reset = rs; press_n = pn; depress_n = dn; inner_open = io; outer_open = oo;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 1, 1, 0, 0);
    endtask

    typedef struct {
        bit rs, pn, dn, io, oo;
        int lvl;
        bit bsy, flt, dne;
    } vec_t;

    vec_t tbl[17];
    int   done_cnt;

    initial begin
        tbl[0]  = '{0,1,1,0,0, 0,0,0,0};
        tbl[1]  = '{0,0,0,0,0, 0,0,0,0};
        tbl[2]  = '{1,0,0,0,0, 0,0,0,0};
        tbl[3]  = '{1,0,1,1,0, 0,0,0,0};
        tbl[4]  = '{1,1,0,0,0, 0,0,0,0};
        tbl[5]  = '{1,0,1,0,0, 0,1,0,0};
        tbl[6]  = '{1,1,1,0,0, 0,1,0,0};
        tbl[7]  = '{1,1,1,0,0, 0,1,0,0};
        tbl[8]  = '{1,0,1,0,0, 0,1,0,0};
        tbl[9]  = '{1,1,1,0,0, 1,1,0,0};
        tbl[10] = '{1,1,1,0,1, 1,1,1,0};
        tbl[11] = '{1,1,0,0,1, 1,1,1,0};
        tbl[12] = '{1,1,1,0,0, 1,1,0,0};
        tbl[13] = '{1,1,1,0,0, 1,1,0,0};
        tbl[14] = '{1,1,1,0,0, 1,1,0,0};
        tbl[15] = '{1,1,1,0,0, 0,0,0,1};
        tbl[16] = '{1,1,1,0,0, 0,0,0,0};

        reset = 1'b0; press_n = 1'b1; depress_n = 1'b1; inner_open = 1'b0; outer_open = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rs, tbl[i].pn, tbl[i].dn, tbl[i].io, tbl[i].oo);
            if (i == 1) sb_en = 1'b1;
            chk($sformatf("tbl%0d_level", i), level_a, tbl[i].lvl);
            chk($sformatf("tbl%0d_busy", i),  busy_a,  tbl[i].bsy);
            chk($sformatf("tbl%0d_fault", i), fault_a, tbl[i].flt);
            chk($sformatf("tbl%0d_done", i),  done_a,  tbl[i].dne);
        end

        // Full ramp on both instances from one press pulse.
        cyc(0, 1, 1, 0, 0);
        chk("rst_depr", depr_a, 1);
        cyc(1, 0, 1, 0, 0);
        chk("ramp_busy0", busy_a, 1);
        done_cnt = 0;
        for (int m = 1; m <= 33; m++) begin
            idle(1);
            if (done_a) done_cnt++;
            if (m == 3)  chk("ramp_a_m3",  level_a, 0);
            if (m == 4)  chk("ramp_a_m4",  level_a, 1);
            if (m == 14) chk("ramp_b_m14", level_b, 14);
            if (m == 15) begin
                chk("ramp_b_top",  level_b, 15);
                chk("ramp_b_done", done_b,  1);
            end
            if (m == 31) chk("ramp_a_m31", level_a, 7);
            if (m == 32) begin
                chk("ramp_a_top",   level_a, 8);
                chk("ramp_a_press", press_a, 1);
                chk("ramp_a_done",  done_a,  1);
                chk("ramp_a_idle",  busy_a,  0);
                chk("ramp_b_hold15", level_b, 15);
            end
        end
        chk("ramp_done_once", done_cnt, 1);

        // Depress request ignored while a door is open, honoured once closed.
        cyc(1, 1, 0, 1, 0);
        chk("dep_door_busy", busy_a, 0);
        chk("dep_door_lvl",  level_a, 8);
        cyc(1, 1, 0, 0, 0);
        chk("dep_busy", busy_a, 1);
        idle(31);
        chk("dep_m31", level_a, 1);
        idle(1);
        chk("dep_zero", level_a, 0);
        chk("dep_done", done_a, 1);
        chk("dep_depr", depr_a, 1);

        // Pause at level 3 count 2, then resume.
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        idle(14);
        chk("pause_pre", level_a, 3);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1, 0, 1);
            chk("pause_fault", fault_a, 1);
            chk("pause_lvl",   level_a, 3);
        end
        idle(1);
        chk("resume1_lvl",   level_a, 3);
        chk("resume1_fault", fault_a, 0);
        idle(1);
        chk("resume2_lvl", level_a, 4);

        // Reversal at level 5.
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        idle(20);
        chk("rev_pre", level_a, 5);
        cyc(1, 1, 0, 0, 0);
        chk("rev_busy", busy_a, 1);
        idle(3);
        chk("rev_m3", level_a, 5);
        idle(1);
        chk("rev_m4", level_a, 4);

        // Reset mid-ramp at level 6.
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        idle(24);
        chk("mid_pre", level_a, 6);
        cyc(0, 0, 1, 0, 0);
        chk("mid_lvl",  level_a, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_depr", depr_a, 1);

        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0);
        end

        sb_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
